// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter fed by a byte FIFO.
// Ports: clk, reset (async, active-high); memWriteInput/memReadInput,
//   addressInput, writeDataInput (bus in); readDataOutput (status or 0);
//   txOutput (serial line, idle high, registered); busyOutput.
module io_uart_tx #(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0F00,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memWriteInput,
    input  logic        memReadInput,
    input  logic [31:0] addressInput,
    input  logic [31:0] writeDataInput,
    output logic [31:0] readDataOutput,
    output logic        txOutput,
    output logic        busyOutput
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;

    logic hit_data, hit_stat;
    logic full, empty, baud_end;
    logic push_req, push, pop;
    logic [31:0] status;

    assign hit_data = addressInput == BASE_ADDRESS;
    assign hit_stat = addressInput == BASE_ADDRESS + 32'd4;

    assign full     = cnt_q == DEPTH_C;
    assign empty    = cnt_q == '0;
    assign baud_end = baud_q == BAUD_LAST;

    // The shifter takes a new byte from IDLE, or straight out of the
    // last stop-bit cycle so back-to-back frames have no idle gap.
    assign pop = !empty &&
                 (state_q == IDLE || (state_q == STOP && baud_end));

    // A push into a full FIFO still fits when a pop frees a slot
    // on the same edge.
    assign push_req = memWriteInput && hit_data;
    assign push     = push_req && (!full || pop);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end else if (memWriteInput && hit_stat && writeDataInput[3]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= writeDataInput[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Line level is registered from the pre-edge state, so the pin
    // trails the state register by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_q];
                        baud_q  <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (baud_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (baud_end) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rd_q];
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        status          = '0;
        status[0]       = full;
        status[1]       = empty;
        status[2]       = state_q != IDLE;
        status[3]       = ovf_q;
        status[4 +: CW] = cnt_q;
    end

    assign readDataOutput = hit_stat ? status : 32'h0;
    assign txOutput       = tx_q;
    assign busyOutput     = !empty || state_q != IDLE;

    // Reads are side-effect free and only the low byte is transmitted.
    logic unused_bits;
    assign unused_bits = ^{memReadInput, writeDataInput[31:8]};

endmodule
